// File: rtl/sync_down_counter_4bit.sv
// rtl/sync_down_counter_4bit.sv - loadable down counter with one-shot / auto-reload modes
// IDLE/RUN/DONE FSM; busy and done decode straight from the state register.
module sync_down_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (en) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            state_d = auto_reload ? ST_RUN : ST_DONE;
                        end else if (auto_reload) begin
                            // Zero is held for one enabled cycle before reloading,
                            // giving a period of reload value + 1.
                            count_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: count_d = '0;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sync_down_counter_4bit.sv
// tb/tb_sync_down_counter_4bit.sv - self-checking bench for sync_down_counter_4bit
module tb_sync_down_counter_4bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       auto_reload;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    sync_down_counter_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       e;
        logic       ar;
        int         x_count;
        int         x_tc;
        int         x_busy;
        int         x_done;
    } vec_t;

    vec_t tbl[$];

    // Reference model: counter value, stored period, phase (0 idle, 1 running, 2 finished)
    int m_count, m_reload, m_phase, m_tc;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int c, input int t, input int b, input int d);
        cmp({name, ".count"}, int'(count), c);
        cmp({name, ".tc"}, int'(tc), t);
        cmp({name, ".busy"}, int'(busy), b);
        cmp({name, ".done"}, int'(done), d);
    endtask

    task automatic drive(input logic l, input logic [3:0] lv, input logic e, input logic ar);
        load = l; load_val = lv; en = e; auto_reload = ar;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_step(input logic r, input logic l, input int lv, input logic e, input logic ar);
        m_tc = 0;
        if (r) begin
            m_count = 0; m_reload = 0; m_phase = 0;
        end else if (l) begin
            m_count = lv; m_reload = lv; m_phase = (lv != 0) ? 1 : 0;
        end else if (m_phase == 1 && e) begin
            if (m_count == 1) begin
                m_count = 0; m_tc = 1;
                if (!ar) m_phase = 2;
            end else if (m_count == 0) begin
                if (ar) m_count = m_reload;
                else m_phase = 2;
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    function automatic vec_t mk(logic l, logic [3:0] lv, logic e, logic ar, int c, int t, int b, int d);
        vec_t v;
        v.ld = l; v.lv = lv; v.e = e; v.ar = ar;
        v.x_count = c; v.x_tc = t; v.x_busy = b; v.x_done = d;
        return v;
    endfunction

    initial begin
        // one-shot from 5
        tbl.push_back(mk(1, 5, 1, 0, 5, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        // reload from DONE, then load wins at count 1
        tbl.push_back(mk(1, 7, 1, 0, 7, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 6, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 9, 0, 1, 0));
        // load of zero parks in IDLE
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        // auto-reload from 3, mode dropped near the end
        tbl.push_back(mk(1, 3, 1, 1, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        #3;
        check_all("reset_async", 0, 0, 0, 0);
        #9 rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        cycle();
        check_all("idle_after_reset", 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ld, tbl[i].lv, tbl[i].e, tbl[i].ar);
            cycle();
            check_all($sformatf("vec%0d", i), tbl[i].x_count, tbl[i].x_tc, tbl[i].x_busy, tbl[i].x_done);
        end

        // enable gap: 9 down to 6, hold 3 cycles, resume to 0
        begin
            int exp_seq[16] = '{9, 8, 7, 6, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0};
            for (int k = 0; k < 13; k++) begin
                drive(k == 0, 4'd9, !(k >= 4 && k <= 6), 0);
                cycle();
                cmp($sformatf("gap%0d.count", k), int'(count), exp_seq[k]);
                cmp($sformatf("gap%0d.tc", k), int'(tc), (k == 12) ? 1 : 0);
            end
        end

        // auto-reload period of 4 with busy held
        for (int k = 0; k < 13; k++) begin
            drive(k == 0, 4'd3, 1, 1);
            cycle();
            cmp($sformatf("ar%0d.count", k), int'(count), 3 - (k % 4));
            cmp($sformatf("ar%0d.tc", k), int'(tc), (k % 4 == 3) ? 1 : 0);
            cmp($sformatf("ar%0d.busy", k), int'(busy), 1);
        end

        // mid-run reset at count 4, load during reset ignored
        drive(1, 4'd6, 1, 0);
        cycle();
        drive(0, 0, 1, 0);
        cycle();
        cycle();
        check_all("pre_rst", 4, 0, 1, 0);
        #2 rst = 1'b1;
        #1 check_all("mid_rst_async", 0, 0, 0, 0);
        drive(1, 4'd5, 1, 0);
        @(negedge clk);
        cycle();
        check_all("load_in_rst", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_all($sformatf("post_rst%0d", k), 0, 0, 0, 0);
        end

        // randomized run against the reference model
        rst = 1'b1;
        cycle();
        model_step(1, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic       r_rst, r_ld, r_en, r_ar;
            logic [3:0] r_lv;
            r_rst = ($urandom_range(0, 63) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_lv  = 4'($urandom_range(0, 15));
            r_en  = ($urandom_range(0, 3) != 0);
            r_ar  = (k % 64) < 40 ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 15) == 0);
            rst = r_rst;
            drive(r_ld, r_lv, r_en, r_ar);
            @(posedge clk);
            model_step(r_rst, r_ld, int'(r_lv), r_en, r_ar);
            @(negedge clk);
            check_all($sformatf("rnd%0d", k), m_count, m_tc, (m_phase == 1) ? 1 : 0, (m_phase == 2) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_down_counter_4bit.md
SYNC_DOWN_COUNTER_4BIT -- requirements
Module: sync_down_counter_4bit

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits; all counter-width ports SHALL use WIDTH.
REQ-002 Port: clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  count enable; when low in RUN, all state holds.
REQ-005 Port: load  input  1  synchronous load strobe.
REQ-006 Port: load_val  input  WIDTH  start/reload value, sampled when load=1.
REQ-007 Port: auto_reload  input  1  mode select: 1 = periodic reload, 0 = one-shot.
REQ-008 Port: count  output  WIDTH  current counter value, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
REQ-010 Port: busy  output  1  high while in state RUN.
REQ-011 Port: done  output  1  high while in state DONE.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, and busy/done SHALL decode directly from the state register.
REQ-013 load=1 SHALL take priority over en and state: count<=load_val and reload_reg<=load_val; state<=RUN if load_val!=0, else IDLE with count=0; tc<=0.
REQ-014 In RUN with en=1 and count>1, count SHALL decrement by 1 per cycle; tc=0.
REQ-015 In RUN with en=1 and count==1: count<=0 and tc<=1 in the same edge; state<=DONE if auto_reload=0, else it stays RUN.
REQ-016 In RUN with en=1, count==0 and auto_reload=1: count<=reload_reg, tc<=0; the reload period SHALL therefore be reload_reg+1 enabled cycles.
REQ-017 In RUN with en=1, count==0 and auto_reload=0 (mode dropped mid-run): state<=DONE, count holds 0, with no additional tc.
REQ-018 In RUN with en=0, count and state SHALL hold; tc<=0 (any tc pulse still ends after one cycle).
REQ-019 auto_reload SHALL be sampled on every edge; a mode change affects only the next terminal decision.
REQ-020 In DONE, count SHALL hold 0 and tc=0 regardless of en; only load or rst leaves DONE.
REQ-021 In IDLE, count SHALL hold and tc=0 regardless of en; only load leaves IDLE.
REQ-022 There SHALL be no wrap from 0 to 2^WIDTH-1 under any input combination.
REQ-023 Load latency SHALL be 1 cycle (count shows load_val after the loading edge); the first decrement occurs on the following enabled edge.
REQ-024 An unused state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-025 While rst=1, outputs SHALL immediately, without waiting for clk, read count=0, tc=0, busy=0 and done=0, with state=IDLE and reload_reg=0.
REQ-026 Reset asserted mid-count SHALL abort the count; after deassertion the block SHALL stay in IDLE until a load.
REQ-027 load coincident with rst=1 SHALL be ignored.

Verification
REQ-028 Reset: assert rst for 12 ns, clk period 10 ns -> count=0, busy=0, done=0, tc=0 asynchronously; block holds IDLE with en=1 and no load.
REQ-029 One-shot: auto_reload=0, load_val=5, en=1 -> count 5,4,3,2,1,0; tc high exactly in the cycle count=0; done=1 and busy=0 thereafter, count stays 0.
REQ-030 Auto-reload: auto_reload=1, load_val=3, en=1 -> count 3,2,1,0,3,2,1,0...; tc pulses every 4 cycles; busy stays 1.
REQ-031 Enable gap: load_val=9, drop en for 3 cycles at count=6 -> count holds 6 for 3 cycles, then resumes at 5; no tc until count=0.
REQ-032 Priority/edge: load_val=0 -> IDLE with count=0 and no tc; load_val=7 during DONE -> RUN at count=7; load at count=1 -> the load wins and no tc is generated.
REQ-033 Mid-run reset: assert rst at count=4 in RUN -> count=0 and busy=0 immediately; after release, en=1 without load leaves count at 0 in IDLE.
